// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts one decoded RV32I arithmetic/logic instruction at a time.
// It decodes the instruction to a 4-bit ALU control code and drives registered
// operands to an external combinational ALU for one cycle.
// It then returns the captured result, or an illegal flag, on a response channel.
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic [6:0]  reqOpcode,
    input  logic [2:0]  reqFunct3,
    input  logic [6:0]  reqFunct7,
    input  logic [31:0] reqRs1Val,
    input  logic [31:0] reqRs2Val,
    input  logic [31:0] reqImm,
    output logic [3:0]  aluCtrl,
    output logic [31:0] aluOp1,
    output logic [31:0] aluOp2,
    input  logic [31:0] aluResult,
    output logic        rspValid,
    input  logic        rspReady,
    output logic [31:0] rspData,
    output logic        rspIllegal
);

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic        dec_legal;
    logic [3:0]  dec_ctrl;
    logic [31:0] dec_op2;

    // Decode the incoming request into legality, ALU control code and second operand.
    always_comb begin
        dec_legal = 1'b0;
        dec_ctrl  = CTRL_ADD;
        dec_op2   = reqRs2Val;
        case (reqOpcode)
            OPC_R: begin
                dec_op2 = reqRs2Val;
                case (reqFunct3)
                    3'b000: begin
                        if (reqFunct7 == F7_BASE) begin
                            dec_legal = 1'b1;
                            dec_ctrl  = CTRL_ADD;
                        end else if (reqFunct7 == F7_ALT) begin
                            dec_legal = 1'b1;
                            dec_ctrl  = CTRL_SUB;
                        end
                    end
                    3'b111: begin
                        dec_legal = (reqFunct7 == F7_BASE);
                        dec_ctrl  = CTRL_AND;
                    end
                    3'b110: begin
                        dec_legal = (reqFunct7 == F7_BASE);
                        dec_ctrl  = CTRL_OR;
                    end
                    3'b010: begin
                        dec_legal = (reqFunct7 == F7_BASE);
                        dec_ctrl  = CTRL_SLT;
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            OPC_I: begin
                dec_op2 = reqImm;
                case (reqFunct3)
                    3'b000: begin
                        dec_legal = 1'b1;
                        dec_ctrl  = CTRL_ADD;
                    end
                    3'b111: begin
                        dec_legal = 1'b1;
                        dec_ctrl  = CTRL_AND;
                    end
                    3'b110: begin
                        dec_legal = 1'b1;
                        dec_ctrl  = CTRL_OR;
                    end
                    3'b010: begin
                        dec_legal = 1'b1;
                        dec_ctrl  = CTRL_SLT;
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Issue FSM: the ALU registers are only loaded on a legal accept.
    // The response registers are only loaded on leaving IDLE or EXEC,
    // so both hold steady everywhere else.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            aluCtrl    <= CTRL_ADD;
            aluOp1     <= 32'd0;
            aluOp2     <= 32'd0;
            rspData    <= 32'd0;
            rspIllegal <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (reqValid) begin
                        if (dec_legal) begin
                            aluCtrl <= dec_ctrl;
                            aluOp1  <= reqRs1Val;
                            aluOp2  <= dec_op2;
                            state   <= EXEC;
                        end else begin
                            rspData    <= 32'd0;
                            rspIllegal <= 1'b1;
                            state      <= RESP;
                        end
                    end
                end
                EXEC: begin
                    rspData    <= aluResult;
                    rspIllegal <= 1'b0;
                    state      <= RESP;
                end
                RESP: begin
                    if (rspReady) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign reqReady = (state == IDLE);
    assign rspValid = (state == RESP);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed tests for alu_issue_ctrl with a behavioural ALU attached.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        reset;
    logic        reqValid;
    logic        reqReady;
    logic [6:0]  reqOpcode;
    logic [2:0]  reqFunct3;
    logic [6:0]  reqFunct7;
    logic [31:0] reqRs1Val;
    logic [31:0] reqRs2Val;
    logic [31:0] reqImm;
    logic [3:0]  aluCtrl;
    logic [31:0] aluOp1;
    logic [31:0] aluOp2;
    logic [31:0] aluResult;
    logic        rspValid;
    logic        rspReady;
    logic [31:0] rspData;
    logic        rspIllegal;

    int checks = 0;
    int errors = 0;

    alu_issue_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .reqValid   (reqValid),
        .reqReady   (reqReady),
        .reqOpcode  (reqOpcode),
        .reqFunct3  (reqFunct3),
        .reqFunct7  (reqFunct7),
        .reqRs1Val  (reqRs1Val),
        .reqRs2Val  (reqRs2Val),
        .reqImm     (reqImm),
        .aluCtrl    (aluCtrl),
        .aluOp1     (aluOp1),
        .aluOp2     (aluOp2),
        .aluResult  (aluResult),
        .rspValid   (rspValid),
        .rspReady   (rspReady),
        .rspData    (rspData),
        .rspIllegal (rspIllegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural combinational ALU driven by the controller.
    always_comb begin
        aluResult = 32'd0;
        case (aluCtrl)
            4'b0000: aluResult = aluOp1 & aluOp2;
            4'b0001: aluResult = aluOp1 | aluOp2;
            4'b0010: aluResult = aluOp1 + aluOp2;
            4'b0110: aluResult = aluOp1 - aluOp2;
            4'b0111: aluResult = ($signed(aluOp1) < $signed(aluOp2)) ? 32'd1 : 32'd0;
            default: aluResult = 32'd0;
        endcase
    end

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_req(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
        reqValid  = 1'b1;
        reqOpcode = op;
        reqFunct3 = f3;
        reqFunct7 = f7;
        reqRs1Val = rs1;
        reqRs2Val = rs2;
        reqImm    = imm;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        rspReady = 1'b1;
        drive_req(7'b0110011, 3'b000, 7'b0000000, 32'd3, 32'd4, 32'd0);
        tick();
        tick();
        checks++;
        if (reqReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_reqReady: got %b expected 1", reqReady); end
        checks++;
        if (rspValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rspValid: got %b expected 0", rspValid); end
        checks++;
        if (aluCtrl !== 4'b0010) begin errors++; $display("[TB] FAIL reset_aluCtrl: got %b expected 0010", aluCtrl); end
        checks++;
        if (aluOp1 !== 32'd0 || aluOp2 !== 32'd0) begin
            errors++; $display("[TB] FAIL reset_aluOps: got %h/%h expected 0/0", aluOp1, aluOp2);
        end
        checks++;
        if (rspData !== 32'd0 || rspIllegal !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_rsp: got %h/%b expected 0/0", rspData, rspIllegal);
        end
        reqValid = 1'b0;
        reset    = 1'b0;
        tick();
        checks++;
        if (reqReady !== 1'b1 || rspValid !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_release: got ready=%b valid=%b expected 1/0", reqReady, rspValid);
        end
    endtask

    task automatic test_add();
        drive_req(7'b0110011, 3'b000, 7'b0000000, 32'd5, 32'd7, 32'hDEAD);
        tick();
        reqValid = 1'b0;
        checks++;
        if (aluCtrl !== 4'b0010 || aluOp1 !== 32'd5 || aluOp2 !== 32'd7) begin
            errors++; $display("[TB] FAIL add_exec: got %b %h %h expected 0010 5 7", aluCtrl, aluOp1, aluOp2);
        end
        checks++;
        if (rspValid !== 1'b0 || reqReady !== 1'b0) begin
            errors++; $display("[TB] FAIL add_exec_hs: got valid=%b ready=%b expected 0/0", rspValid, reqReady);
        end
        tick();
        checks++;
        if (rspValid !== 1'b1 || rspData !== 32'd12 || rspIllegal !== 1'b0) begin
            errors++; $display("[TB] FAIL add_resp: got %b %h %b expected 1 0000000c 0", rspValid, rspData, rspIllegal);
        end
        tick();
        checks++;
        if (rspValid !== 1'b0 || reqReady !== 1'b1) begin
            errors++; $display("[TB] FAIL add_done: got valid=%b ready=%b expected 0/1", rspValid, reqReady);
        end
    endtask

    task automatic test_sub_wrap();
        drive_req(7'b0110011, 3'b000, 7'b0100000, 32'd0, 32'd1, 32'd0);
        tick();
        reqValid = 1'b0;
        checks++;
        if (aluCtrl !== 4'b0110) begin errors++; $display("[TB] FAIL sub_ctrl: got %b expected 0110", aluCtrl); end
        tick();
        checks++;
        if (rspValid !== 1'b1 || rspData !== 32'hFFFF_FFFF) begin
            errors++; $display("[TB] FAIL sub_resp: got %b %h expected 1 ffffffff", rspValid, rspData);
        end
        tick();
    endtask

    task automatic test_slti();
        drive_req(7'b0010011, 3'b010, 7'b1111111, 32'hFFFF_FFFF, 32'd99, 32'd1);
        tick();
        reqValid = 1'b0;
        checks++;
        if (aluCtrl !== 4'b0111 || aluOp1 !== 32'hFFFF_FFFF || aluOp2 !== 32'd1) begin
            errors++; $display("[TB] FAIL slti_exec: got %b %h %h expected 0111 ffffffff 1", aluCtrl, aluOp1, aluOp2);
        end
        tick();
        checks++;
        if (rspData !== 32'd1 || rspIllegal !== 1'b0) begin
            errors++; $display("[TB] FAIL slti_resp: got %h %b expected 1 0", rspData, rspIllegal);
        end
        tick();
    endtask

    task automatic test_illegal();
        logic [6:0] ops [3];
        logic [2:0] f3s [3];
        logic [6:0] f7s [3];
        ops[0] = 7'b0110011; f3s[0] = 3'b001; f7s[0] = 7'b0000000;
        ops[1] = 7'b0110011; f3s[1] = 3'b000; f7s[1] = 7'b0000001;
        ops[2] = 7'b0110111; f3s[2] = 3'b000; f7s[2] = 7'b0000000;
        for (int i = 0; i < 3; i++) begin
            drive_req(ops[i], f3s[i], f7s[i], 32'd123, 32'd456, 32'd789);
            tick();
            reqValid = 1'b0;
            checks++;
            if (rspValid !== 1'b1 || rspIllegal !== 1'b1 || rspData !== 32'd0) begin
                errors++; $display("[TB] FAIL illegal_resp[%0d]: got %b %b %h expected 1 1 0", i, rspValid, rspIllegal, rspData);
            end
            checks++;
            if (aluCtrl !== 4'b0111 || aluOp1 !== 32'hFFFF_FFFF || aluOp2 !== 32'd1) begin
                errors++; $display("[TB] FAIL illegal_alu_hold[%0d]: got %b %h %h expected 0111 ffffffff 1", i, aluCtrl, aluOp1, aluOp2);
            end
            tick();
            checks++;
            if (rspValid !== 1'b0 || reqReady !== 1'b1) begin
                errors++; $display("[TB] FAIL illegal_done[%0d]: got valid=%b ready=%b expected 0/1", i, rspValid, reqReady);
            end
        end
    endtask

    task automatic test_or_and();
        drive_req(7'b0010011, 3'b110, 7'b1010101, 32'h0000_F000, 32'd0, 32'h0000_000F);
        tick();
        reqValid = 1'b0;
        checks++;
        if (aluCtrl !== 4'b0001 || aluOp2 !== 32'h0000_000F) begin
            errors++; $display("[TB] FAIL ori_exec: got %b %h expected 0001 0000000f", aluCtrl, aluOp2);
        end
        tick();
        checks++;
        if (rspData !== 32'h0000_F00F) begin errors++; $display("[TB] FAIL ori_resp: got %h expected 0000f00f", rspData); end
        tick();
        drive_req(7'b0110011, 3'b111, 7'b0000000, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'd0);
        tick();
        reqValid = 1'b0;
        tick();
        checks++;
        if (rspData !== 32'h0F00_0F00 || rspIllegal !== 1'b0) begin
            errors++; $display("[TB] FAIL and_resp: got %h %b expected 0f000f00 0", rspData, rspIllegal);
        end
        tick();
    endtask

    task automatic test_backpressure();
        rspReady = 1'b0;
        drive_req(7'b0010011, 3'b111, 7'b0000000, 32'h0000_F0F0, 32'd0, 32'h0000_0FF0);
        tick();
        checks++;
        if (aluCtrl !== 4'b0000 || aluOp2 !== 32'h0000_0FF0) begin
            errors++; $display("[TB] FAIL andi_exec: got %b %h expected 0000 00000ff0", aluCtrl, aluOp2);
        end
        drive_req(7'b0110011, 3'b000, 7'b0000000, 32'd1, 32'd1, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (rspValid !== 1'b1 || rspData !== 32'h0000_00F0 || reqReady !== 1'b0) begin
                errors++; $display("[TB] FAIL bp_hold[%0d]: got %b %h ready=%b expected 1 000000f0 0", i, rspValid, rspData, reqReady);
            end
        end
        rspReady = 1'b1;
        tick();
        checks++;
        if (rspValid !== 1'b0 || reqReady !== 1'b1) begin
            errors++; $display("[TB] FAIL bp_release: got valid=%b ready=%b expected 0/1", rspValid, reqReady);
        end
        tick();
        reqValid = 1'b0;
        checks++;
        if (reqReady !== 1'b0 || aluCtrl !== 4'b0010 || aluOp1 !== 32'd1) begin
            errors++; $display("[TB] FAIL bp_next_accept: got ready=%b %b %h expected 0 0010 1", reqReady, aluCtrl, aluOp1);
        end
        tick();
        checks++;
        if (rspData !== 32'd2) begin errors++; $display("[TB] FAIL bp_next_resp: got %h expected 2", rspData); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [4:0] expValid;
        logic [4:0] expReady;
        expValid = 5'b10010;
        expReady = 5'b00100;
        drive_req(7'b0110011, 3'b000, 7'b0000000, 32'd10, 32'd20, 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rspValid !== expValid[i] || reqReady !== expReady[i]) begin
                errors++; $display("[TB] FAIL b2b[%0d]: got valid=%b ready=%b expected %b/%b", i, rspValid, reqReady, expValid[i], expReady[i]);
            end
            if (i == 4) begin
                checks++;
                if (rspData !== 32'd30) begin errors++; $display("[TB] FAIL b2b_data: got %h expected 1e", rspData); end
                reqValid = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_exec();
        drive_req(7'b0110011, 3'b000, 7'b0100000, 32'd9, 32'd4, 32'd0);
        tick();
        reqValid = 1'b0;
        checks++;
        if (aluCtrl !== 4'b0110 || reqReady !== 1'b0) begin
            errors++; $display("[TB] FAIL mid_exec_pre: got %b ready=%b expected 0110 0", aluCtrl, reqReady);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (aluCtrl !== 4'b0010 || aluOp1 !== 32'd0 || aluOp2 !== 32'd0 || rspData !== 32'd0 ||
            rspIllegal !== 1'b0 || rspValid !== 1'b0 || reqReady !== 1'b1) begin
            errors++; $display("[TB] FAIL mid_exec_reset: got %b %h %h %h %b v=%b r=%b expected 0010 0 0 0 0 0 1",
                               aluCtrl, aluOp1, aluOp2, rspData, rspIllegal, rspValid, reqReady);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (rspValid !== 1'b0 || reqReady !== 1'b1) begin
                errors++; $display("[TB] FAIL mid_exec_after[%0d]: got valid=%b ready=%b expected 0/1", i, rspValid, reqReady);
            end
        end
    endtask

    // Run all scenarios in order and report.
    initial begin
        reset     = 1'b1;
        reqValid  = 1'b0;
        rspReady  = 1'b1;
        reqOpcode = 7'd0;
        reqFunct3 = 3'd0;
        reqFunct7 = 7'd0;
        reqRs1Val = 32'd0;
        reqRs2Val = 32'd0;
        reqImm    = 32'd0;
        @(negedge clk);
        test_reset();
        test_add();
        test_sub_wrap();
        test_slti();
        test_illegal();
        test_or_and();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_exec();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
